cache_miss_ctrl: RTL and testbench

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

---
 rtl/cache_miss_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Direct-mapped cache miss/write-through controller: 4-word refill on read miss, no write-allocate; stalls until memory handshakes finish.
// Statistics counters only exist when CACHE_MISS_STATS_EN is defined; otherwise hit_count/miss_count are tied to 0.
module cache_miss_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MEM_SIZE   = 32,
  parameter int LINE_WORDS = 4,
  localparam int AW = $clog2(MEM_SIZE),
  localparam int OW = $clog2(LINE_WORDS),
  localparam int TW = AW - OW - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic             hit,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             stall,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cache_we,
  output logic             cache_index,
  output logic [OW-1:0]    cache_offset,
  output logic [WIDTH-1:0] cache_wdata,
  output logic             tag_we,
  output logic [TW-1:0]    tag_out,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
);

  typedef enum logic [2:0] {IDLE, REFILL, TAG, WRITE, DONE} state_t;

  state_t           state;
  logic [OW-1:0]    cnt;
  logic [AW-1:0]    cap_addr;
  logic             cap_write;
  logic             cap_hit;
  logic [WIDTH-1:0] cap_wdata;
  logic             first_wr;

  logic [TW-1:0]    cap_tag;
  logic             cap_index;
  logic [OW-1:0]    cap_offset;

  assign cap_tag    = cap_addr[AW-1:OW+1];
  assign cap_index  = cap_addr[OW];
  assign cap_offset = cap_addr[OW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      resp_data <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_hit   <= 1'b0;
      cap_wdata <= '0;
      first_wr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_addr  <= req_addr;
            cap_write <= req_write;
            cap_wdata <= req_wdata;
            cap_hit   <= hit;
            if (req_write) begin
              state    <= WRITE;
              first_wr <= 1'b1;
            end else if (!hit) begin
              state <= REFILL;
              cnt   <= '0;
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (cnt == cap_offset) resp_data <= mem_rdata;
            // cnt wraps back to 0 naturally as the last word is accepted
            cnt <= cnt + 1'b1;
            if (cnt == OW'(LINE_WORDS - 1)) state <= TAG;
          end
        end
        TAG:   state <= DONE;
        WRITE: begin
          first_wr <= 1'b0;
          if (mem_ready) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall        = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_addr     = cap_addr;
    mem_wdata    = cap_wdata;
    cache_we     = 1'b0;
    cache_index  = cap_index;
    cache_offset = cap_offset;
    cache_wdata  = cap_wdata;
    tag_we       = 1'b0;
    tag_out      = cap_tag;
    resp_valid   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: stall = req_valid && (req_write || !hit);
        REFILL: begin
          stall        = 1'b1;
          mem_rd_en    = 1'b1;
          mem_addr     = {cap_tag, cap_index, cnt};
          cache_we     = mem_ready;
          cache_offset = cnt;
          cache_wdata  = mem_rdata;
        end
        TAG: begin
          stall  = 1'b1;
          tag_we = 1'b1;
        end
        WRITE: begin
          stall     = 1'b1;
          mem_wr_en = 1'b1;
          // only a write hit updates the cached copy, and only once
          cache_we  = cap_hit && first_wr;
        end
        DONE:    resp_valid = !cap_write;
        default: ;
      endcase
    end
  end

`ifdef CACHE_MISS_STATS_EN
  logic [15:0] hit_q;
  logic [15:0] miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == IDLE && req_valid && !req_write) begin
      if (hit && hit_q != 16'hFFFF)   hit_q  <= hit_q + 16'd1;
      if (!hit && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: hits, refill, write hit/miss, reset mid-refill, statistics.
module tb_cache_miss_ctrl;

`ifdef CACHE_MISS_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        hit;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cache_we;
  logic        cache_index;
  logic [1:0]  cache_offset;
  logic [31:0] cache_wdata;
  logic        tag_we;
  logic [1:0]  tag_out;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  cache_miss_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .hit(hit),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cache_we(cache_we), .cache_index(cache_index),
    .cache_offset(cache_offset), .cache_wdata(cache_wdata), .tag_we(tag_we),
    .tag_out(tag_out), .resp_valid(resp_valid), .resp_data(resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive a refill starting at word address base; returns positioned in the TAG cycle.
  task automatic run_refill(input int base, input int data0, input bit every_other,
                            input int exp_tag, input int exp_index);
    int  words = 0;
    bit  seen  = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      mem_ready = every_other ? c[0] : 1'b1;
      mem_rdata = data0 + words;
      #1;
      if (tag_we) begin
        seen = 1;
        chk("tag_out", tag_out, exp_tag);
        chk("tag_index", cache_index, exp_index);
        chk("tag_stall", stall, 1);
        chk("tag_rd_en", mem_rd_en, 0);
      end else begin
        chk("rf_rd_en", mem_rd_en, 1);
        chk("rf_wr_en", mem_wr_en, 0);
        chk("rf_addr", mem_addr, base + words);
        chk("rf_stall", stall, 1);
        if (mem_ready) begin
          chk("rf_cache_we", cache_we, 1);
          chk("rf_offset", cache_offset, words);
          chk("rf_cwdata", cache_wdata, data0 + words);
          words++;
        end else begin
          chk("rf_cache_we_idle", cache_we, 0);
        end
        tick();
      end
    end
    chk("rf_words", words, 4);
    chk("rf_tag_seen", seen, 1);
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd0;
    req_wdata = 32'd0; hit = 1'b0; mem_rdata = 32'd0; mem_ready = 1'b0;

    // reset: strobes low even with a would-be miss presented
    tick(); #1;
    chk("rst_stall", stall, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    tick();
    rst = 1'b0;

    // three read hits
    req_valid = 1'b1; hit = 1'b1; req_addr = 5'b10_1_01; #1;
    chk("hit_stall", stall, 0);
    chk("hit_rd_en", mem_rd_en, 0);
    tick(); req_addr = 5'b00_0_00; #1;
    chk("hit2_stall", stall, 0);
    tick(); req_addr = 5'b11_1_10; #1;
    chk("hit3_rd_en", mem_rd_en, 0);
    tick(); req_valid = 1'b0; #1;
    chk("hit_idle_stall", stall, 0);

    // read miss, memory ready every second cycle
    req_valid = 1'b1; hit = 1'b0; req_addr = 5'b01_0_10; #1;
    chk("miss_stall_comb", stall, 1);
    chk("miss_rd_en_idle", mem_rd_en, 0);
    tick();
    req_valid = 1'b1; hit = 1'b1; req_write = 1'b1; req_addr = 5'b11_1_11;
    run_refill(8, 100, 1'b1, 1, 0);
    tick(); req_valid = 1'b1; hit = 1'b0; req_write = 1'b0; #1;
    chk("done_resp_valid", resp_valid, 1);
    chk("done_resp_data", resp_data, 102);
    chk("done_stall", stall, 0);
    tick(); req_valid = 1'b0; #1;
    chk("post_done_stall", stall, 0);
    chk("post_done_rd_en", mem_rd_en, 0);
    chk("post_done_resp_valid", resp_valid, 0);

    // write hit
    req_valid = 1'b1; req_write = 1'b1; hit = 1'b1; req_addr = 5'b11_1_11;
    req_wdata = 32'hDEAD_BEEF; #1;
    chk("wh_stall_comb", stall, 1);
    chk("wh_cache_we_idle", cache_we, 0);
    tick(); req_valid = 1'b0; hit = 1'b0; req_addr = 5'd0; req_wdata = 32'd0; #1;
    chk("wh_wr_en", mem_wr_en, 1);
    chk("wh_rd_en", mem_rd_en, 0);
    chk("wh_addr", mem_addr, 31);
    chk("wh_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wh_cache_we", cache_we, 1);
    chk("wh_index", cache_index, 1);
    chk("wh_offset", cache_offset, 3);
    chk("wh_cwdata", cache_wdata, 32'hDEAD_BEEF);
    tick(); #1;
    chk("wh_wr_en_held", mem_wr_en, 1);
    chk("wh_cache_we_once", cache_we, 0);
    chk("wh_stall_held", stall, 1);
    mem_ready = 1'b1;
    tick(); mem_ready = 1'b0; #1;
    chk("wh_done_resp_valid", resp_valid, 0);
    chk("wh_done_wr_en", mem_wr_en, 0);
    chk("wh_done_stall", stall, 0);
    tick();

    // write miss
    req_valid = 1'b1; req_write = 1'b1; hit = 1'b0; req_addr = 5'b00_1_00;
    req_wdata = 32'h0000_1234;
    tick(); req_valid = 1'b0; req_write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mem_ready = (c == 2); #1;
      chk("wm_wr_en", mem_wr_en, 1);
      chk("wm_rd_en", mem_rd_en, 0);
      chk("wm_cache_we", cache_we, 0);
      chk("wm_tag_we", tag_we, 0);
      chk("wm_wdata", mem_wdata, 32'h0000_1234);
      tick();
    end
    mem_ready = 1'b0; #1;
    chk("wm_done_resp_valid", resp_valid, 0);
    chk("wm_done_cache_we", cache_we, 0);
    chk("wm_done_tag_we", tag_we, 0);
    chk("stats_hit_count", hit_count, STATS ? 3 : 0);
    chk("stats_miss_count", miss_count, STATS ? 1 : 0);
    tick();

    // reset after the second refill word
    req_valid = 1'b1; hit = 1'b0; req_addr = 5'b10_0_01;
    tick(); req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'd0; #1;
    chk("rr_addr0", mem_addr, 16);
    tick(); #1;
    chk("rr_addr1", mem_addr, 17);
    tick(); rst = 1'b1; mem_ready = 1'b0; #1;
    chk("rr_rst_rd_en", mem_rd_en, 0);
    chk("rr_rst_stall", stall, 0);
    chk("rr_rst_cache_we", cache_we, 0);
    tick(); rst = 1'b0; #1;
    chk("rr_idle_rd_en", mem_rd_en, 0);
    chk("rr_idle_tag_we", tag_we, 0);
    chk("rr_idle_stall", stall, 0);
    chk("rr_hit_count", hit_count, 0);
    chk("rr_miss_count", miss_count, 0);
    req_valid = 1'b1; req_addr = 5'b10_0_01; #1;
    chk("rr_miss_stall", stall, 1);
    tick(); req_valid = 1'b0;
    run_refill(16, 200, 1'b0, 2, 0);
    tick(); #1;
    chk("rr_resp_valid", resp_valid, 1);
    chk("rr_resp_data", resp_data, 201);
    chk("rr_miss_count2", miss_count, STATS ? 1 : 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
